// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: read ports, two write ports, load scoreboard and dump stream.
// The dump stream moves one beat on each rising edge where dump_valid && dump_ready; dump_addr/dump_data hold until then.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              use_rs;
  logic              use_rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wm_en;
  logic [ADDR_W-1:0] wm_addr;
  logic [DATA_W-1:0] wm_data;
  logic              ld_issue_en;
  logic [ADDR_W-1:0] ld_issue_addr;
  logic              err_waw;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;
  logic [1:0]        dump_state;

  modport master (
    output rs_addr, rt_addr, use_rs, use_rt,
    output wa_en, wa_addr, wa_data, wm_en, wm_addr, wm_data,
    output ld_issue_en, ld_issue_addr, dump_start, dump_ready,
    input  rs_data, rt_data, stall, err_waw,
    input  dump_valid, dump_addr, dump_data, dump_done, dump_state
  );

  modport slave (
    input  rs_addr, rt_addr, use_rs, use_rt,
    input  wa_en, wa_addr, wa_data, wm_en, wm_addr, wm_data,
    input  ld_issue_en, ld_issue_addr, dump_start, dump_ready,
    output rs_data, rt_data, stall, err_waw,
    output dump_valid, dump_addr, dump_data, dump_done, dump_state
  );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/2-write register file with load-use scoreboard, stall generation and a
// valid/ready register dump stream for the board debug path.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_HW  = 1
) (
  input logic        clock,
  input logic        reset,
  regfile_sb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_waw_q, err_waw_d;
  dump_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic [ADDR_W-1:0]   idx_nxt;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_data;
  logic                rs_busy, rt_busy;

  // Same priority as the write port: ALU writeback is younger than the returning load.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              a_en,
    input logic [ADDR_W-1:0] a_addr,
    input logic [DATA_W-1:0] a_data,
    input logic              m_en,
    input logic [ADDR_W-1:0] m_addr,
    input logic [DATA_W-1:0] m_data
  );
    if (ZERO_HW != 0 && a == '0) return '0;
    if (a_en && a_addr == a)     return a_data;
    if (m_en && m_addr == a)     return m_data;
    return stored;
  endfunction

  assign bus.rs_data = bypass(bus.rs_addr, regs_q[bus.rs_addr], bus.wa_en, bus.wa_addr,
                              bus.wa_data, bus.wm_en, bus.wm_addr, bus.wm_data);
  assign bus.rt_data = bypass(bus.rt_addr, regs_q[bus.rt_addr], bus.wa_en, bus.wa_addr,
                              bus.wa_data, bus.wm_en, bus.wm_addr, bus.wm_data);

  // A load returning this cycle resolves the hazard without waiting for the edge.
  assign rs_busy   = busy_q[bus.rs_addr] && !(bus.wm_en && bus.wm_addr == bus.rs_addr);
  assign rt_busy   = busy_q[bus.rt_addr] && !(bus.wm_en && bus.wm_addr == bus.rt_addr);
  assign bus.stall = (bus.use_rs && rs_busy) || (bus.use_rt && rt_busy);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (!(ZERO_HW != 0 && n == 0)) begin
          if (bus.wa_en && bus.wa_addr == ADDR_W'(n))      regs_q[n] <= bus.wa_data;
          else if (bus.wm_en && bus.wm_addr == ADDR_W'(n)) regs_q[n] <= bus.wm_data;
        end
      end
    end
  end

  // Issue is applied after clear so a new load on the same register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < NUM_REGS; n++) begin
      if (bus.wm_en && bus.wm_addr == ADDR_W'(n))             busy_d[n] = 1'b0;
      if (bus.ld_issue_en && bus.ld_issue_addr == ADDR_W'(n)) busy_d[n] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign err_waw_d = err_waw_q || (bus.wa_en && busy_q[bus.wa_addr]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      err_waw_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      err_waw_q <= err_waw_d;
    end
  end

  assign bus.err_waw = err_waw_q;

  // Capture address is reg 0 when starting, otherwise the next beat.
  assign idx_nxt  = idx_q + 1'b1;
  assign cap_addr = (state_q == IDLE) ? '0 : idx_nxt;
  assign cap_data = bypass(cap_addr, regs_q[cap_addr], bus.wa_en, bus.wa_addr,
                           bus.wa_data, bus.wm_en, bus.wm_addr, bus.wm_data);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    dump_data_d    = dump_data_q;
    bus.dump_valid = 1'b0;
    bus.dump_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          state_d     = SEND;
          idx_d       = '0;
          dump_data_d = cap_data;
        end
      end
      SEND: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d       = idx_nxt;
            dump_data_d = cap_data;
          end
        end
      end
      DONE: begin
        bus.dump_done = 1'b1;
        state_d       = IDLE;
        idx_d         = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign bus.dump_addr  = idx_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_state = state_q;

endmodule
